// File: rtl/ex_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_iter_unit
// Purpose  : Execute stage with ALU ops plus an iterative mul/div writing HI/LO.
// Revision : 1.0
// ============================================================================
module ex_iter_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int CNT_W   = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    localparam logic [3:0] OP_OR = 4'd0, OP_AND = 4'd1, OP_XOR = 4'd2, OP_NOR = 4'd3,
                           OP_ADD = 4'd4, OP_SUB = 4'd5, OP_SLT = 4'd6, OP_SLTU = 4'd7,
                           OP_SLL = 4'd8, OP_SRL = 4'd9, OP_SRA = 4'd10, OP_MULTU = 4'd11,
                           OP_MULT = 4'd12, OP_DIVU = 4'd13, OP_DIV = 4'd14, OP_NOP = 4'd15;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]   a_raw;
    logic                is_div, neg_p, neg_r, div0;

    logic                is_muldiv, is_signed, a_neg, b_neg, start, accept;
    logic [DATA_W-1:0]   a_mag, b_mag, alu_res;
    logic [SHAMT_W-1:0]  shamt;

    assign is_muldiv = (op_i == OP_MULTU) || (op_i == OP_MULT) ||
                       (op_i == OP_DIVU)  || (op_i == OP_DIV);
    assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign a_neg     = is_signed & a_i[DATA_W-1];
    assign b_neg     = is_signed & b_i[DATA_W-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;
    assign start     = (state == IDLE) && valid_i && is_muldiv && !flush_i;
    assign accept    = (state == IDLE) && valid_i && !is_muldiv && !flush_i;
    assign shamt     = a_i[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op_i)
            OP_OR:   alu_res = a_i | b_i;
            OP_AND:  alu_res = a_i & b_i;
            OP_XOR:  alu_res = a_i ^ b_i;
            OP_NOR:  alu_res = ~(a_i | b_i);
            OP_ADD:  alu_res = a_i + b_i;
            OP_SUB:  alu_res = a_i - b_i;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
            OP_SLL:  alu_res = b_i << shamt;
            OP_SRL:  alu_res = b_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(b_i) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // prod holds {acc, multiplier} for MUL and {remainder, dividend} for DIV.
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic [2*DATA_W-1:0] step_next, mul_res;
    logic [DATA_W-1:0]   quo, rem;

    always_comb begin
        mul_sum   = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, opnd} : '0);
        div_shift = prod[2*DATA_W-1:DATA_W-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div)
            step_next = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], prod[DATA_W-2:0], 1'b0}
                                         : {div_diff[DATA_W-1:0],  prod[DATA_W-2:0], 1'b1};
        else
            step_next = {mul_sum, prod[DATA_W-1:1]};
        mul_res = neg_p ? -step_next : step_next;
        quo     = neg_p ? -step_next[DATA_W-1:0] : step_next[DATA_W-1:0];
        rem     = neg_r ? -step_next[2*DATA_W-1:DATA_W] : step_next[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        stall_o = 1'b0;
        case (state)
            IDLE: begin
                stall_o = valid_i & is_muldiv;
                if (start) state_n = RUN;
            end
            RUN: begin
                stall_o = 1'b1;
                if (count == LAST_STEP) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush_i) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            prod      <= '0;
            opnd      <= '0;
            a_raw     <= '0;
            is_div    <= 1'b0;
            neg_p     <= 1'b0;
            neg_r     <= 1'b0;
            div0      <= 1'b0;
            valid_o   <= 1'b0;
            wd_o      <= '0;
            wreg_o    <= 1'b0;
            wdata_o   <= '0;
            hilo_we_o <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else begin
            valid_o   <= 1'b0;
            wreg_o    <= 1'b0;
            hilo_we_o <= 1'b0;
            if (flush_i) begin
                count <= '0;
            end else if (state == IDLE) begin
                if (accept) begin
                    valid_o <= 1'b1;
                    wd_o    <= wd_i;
                    wreg_o  <= wreg_i && (op_i != OP_NOP);
                    wdata_o <= alu_res;
                end
                if (start) begin
                    count  <= '0;
                    prod   <= {{DATA_W{1'b0}}, a_mag};
                    opnd   <= b_mag;
                    a_raw  <= a_i;
                    is_div <= (op_i == OP_DIVU) || (op_i == OP_DIV);
                    neg_p  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    div0   <= (b_i == '0);
                end
            end else if (state == RUN) begin
                prod  <= step_next;
                count <= count + 1'b1;
                if (count == LAST_STEP) begin
                    valid_o   <= 1'b1;
                    hilo_we_o <= 1'b1;
                    wd_o      <= '0;
                    wdata_o   <= '0;
                    if (!is_div) begin
                        hi_o <= mul_res[2*DATA_W-1:DATA_W];
                        lo_o <= mul_res[DATA_W-1:0];
                    end else if (div0) begin
                        hi_o <= a_raw;
                        lo_o <= '1;
                    end else begin
                        hi_o <= rem;
                        lo_o <= quo;
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ex_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_iter_unit
// Purpose  : Scoreboard bench for ex_iter_unit with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_ex_iter_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [3:0]  op_i = '0;
    logic [31:0] a_i = '0, b_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic        stall_o, valid_o, wreg_o, hilo_we_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    ex_iter_unit #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .wd_i(wd_i), .wreg_i(wreg_i), .stall_o(stall_o),
        .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        md;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata, hi, lo;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t alu(input logic [4:0] wd, input logic wreg, input logic [31:0] r);
        exp_t e;
        e.md = 1'b0; e.wd = wd; e.wreg = wreg; e.wdata = r; e.hi = '0; e.lo = '0;
        return e;
    endfunction

    function automatic exp_t md(input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.md = 1'b1; e.wd = '0; e.wreg = 1'b0; e.wdata = '0; e.hi = hi; e.lo = lo;
        return e;
    endfunction

    // Monitor: every valid_o beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (hilo_we_o && !valid_o) chk("hilo_we_without_valid", 1, 0);
            if (valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hilo_we", hilo_we_o, e.md);
                    chk("wreg", wreg_o, e.wreg);
                    chk("wdata", wdata_o, e.wdata);
                    if (e.md) begin
                        chk("hi", hi_o, e.hi);
                        chk("lo", lo_o, e.lo);
                    end else begin
                        chk("wd", wd_o, e.wd);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns once the instruction has been consumed.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wreg, input exp_t e,
                         output int stalls);
        sb.push_back(e);
        op_i = op; a_i = a; b_i = b; wd_i = wd; wreg_i = wreg; valid_i = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (stall_o && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 100) chk("stall_timeout", stalls, 0);
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    initial begin
        int st;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {valid_o, wreg_o, hilo_we_o, stall_o, wd_o, wdata_o, hi_o, lo_o}, 64'd0);
        @(posedge clk); #1;

        issue(4'd0, 32'hF0F00000, 32'h00000F0F, 5'd3, 1'b1, alu(5'd3, 1'b1, 32'hF0F00F0F), st);
        issue(4'd10, 32'd4, 32'h80000000, 5'd4, 1'b1, alu(5'd4, 1'b1, 32'hF8000000), st);
        issue(4'd6, 32'hFFFFFFFF, 32'd1, 5'd5, 1'b1, alu(5'd5, 1'b1, 32'd1), st);
        issue(4'd7, 32'hFFFFFFFF, 32'd1, 5'd6, 1'b1, alu(5'd6, 1'b1, 32'd0), st);
        issue(4'd1, 32'hFF00FF00, 32'h0F0F0F0F, 5'd7, 1'b1, alu(5'd7, 1'b1, 32'h0F000F00), st);
        issue(4'd2, 32'hFF00FF00, 32'h0F0F0F0F, 5'd8, 1'b0, alu(5'd8, 1'b0, 32'hF00FF00F), st);
        issue(4'd3, 32'd0, 32'd0, 5'd9, 1'b1, alu(5'd9, 1'b1, 32'hFFFFFFFF), st);
        issue(4'd4, 32'hFFFFFFFF, 32'd2, 5'd10, 1'b1, alu(5'd10, 1'b1, 32'd1), st);
        issue(4'd5, 32'd0, 32'd1, 5'd11, 1'b1, alu(5'd11, 1'b1, 32'hFFFFFFFF), st);
        issue(4'd8, 32'h21, 32'd1, 5'd12, 1'b1, alu(5'd12, 1'b1, 32'd2), st);
        issue(4'd9, 32'd4, 32'h80000000, 5'd13, 1'b1, alu(5'd13, 1'b1, 32'h08000000), st);
        issue(4'd15, 32'd1, 32'd2, 5'd14, 1'b1, alu(5'd14, 1'b0, 32'd0), st);

        issue(4'd12, 32'hFFFFFFFD, 32'd7, 5'd1, 1'b1, md(32'hFFFFFFFF, 32'hFFFFFFEB), st);
        chk("mult_stall_cycles", st, 33);
        issue(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1, md(32'hFFFFFFFE, 32'h00000001), st);
        issue(4'd14, 32'hFFFFFFF9, 32'd2, 5'd1, 1'b1, md(32'hFFFFFFFF, 32'hFFFFFFFD), st);
        issue(4'd14, 32'h80000000, 32'hFFFFFFFF, 5'd1, 1'b1, md(32'd0, 32'h80000000), st);
        issue(4'd14, 32'hFFFFFFF9, 32'd0, 5'd1, 1'b1, md(32'hFFFFFFF9, 32'hFFFFFFFF), st);
        issue(4'd13, 32'd5, 32'd0, 5'd1, 1'b1, md(32'd5, 32'hFFFFFFFF), st);
        chk("divu0_stall_cycles", st, 33);

        // DIVU 100/7 annulled at RUN step 10.
        op_i = 4'd13; a_i = 32'd100; b_i = 32'd7; valid_i = 1'b1;
        repeat (11) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        chk("flush_stall_low", stall_o, 0);
        repeat (3) @(negedge clk);
        chk("flush_hi_kept", hi_o, 32'd5);
        chk("flush_lo_kept", lo_o, 32'hFFFFFFFF);
        @(posedge clk); #1;
        issue(4'd0, 32'h00000011, 32'h00000100, 5'd2, 1'b1, alu(5'd2, 1'b1, 32'h00000111), st);

        // Reset during MULTU RUN.
        op_i = 4'd11; a_i = 32'd3; b_i = 32'd4; valid_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; valid_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {valid_o, wreg_o, hilo_we_o, stall_o, wd_o, wdata_o, hi_o, lo_o}, 64'd0);
        @(posedge clk); #1;

        issue(4'd4, 32'd10, 32'd20, 5'd5, 1'b1, alu(5'd5, 1'b1, 32'd30), st);
        issue(4'd11, 32'd6, 32'd7, 5'd9, 1'b1, md(32'd0, 32'd42), st);
        issue(4'd4, 32'd1, 32'd1, 5'd6, 1'b1, alu(5'd6, 1'b1, 32'd2), st);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
